// File: rtl/stage_sequencer.sv
// Active-low one-hot stage sequencer for the multi-cycle CPU pipeline.
// Optional per-stage watchdog enabled by defining STAGE_WATCHDOG_EN.
module stage_sequencer #(
    parameter int         NUM_STAGES      = 5,
    parameter logic [7:0] WATCHDOG_CYCLES = 8'd255
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  stage_done,
    input  logic [NUM_STAGES-1:0] skip,
    input  logic                  halt,
    output logic [NUM_STAGES-1:0] stage_n,
    output logic                  stage_start,
    output logic                  retire,
    output logic [15:0]           retired_count
`ifdef STAGE_WATCHDOG_EN
    ,
    output logic                  timeout
`endif
);

    localparam logic [NUM_STAGES-1:0] FETCH_OH = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0] stage_oh;
    logic [NUM_STAGES-1:0] later_mask;
    logic [NUM_STAGES-1:0] candidates;
    logic [NUM_STAGES-1:0] next_oh;
    logic                  advance;
    logic                  wrap;
    logic                  force_fetch;
    logic                  entered;

    assign stage_oh = ~stage_n;
    assign advance  = stage_done & ~halt;

    // later_mask[j] is set for every stage strictly after the current one
    always_comb begin : later_stages
        logic seen;
        seen = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            later_mask[j] = seen;
            seen          = seen | stage_oh[j];
        end
    end

    // Bit 0 of later_mask is always 0, so skip[0] can never select fetch
    assign candidates = ~skip & later_mask;
    assign wrap       = ~|candidates;

    always_comb begin
        next_oh = '0;
        for (int j = NUM_STAGES - 1; j > 0; j--) begin
            if (candidates[j]) begin
                next_oh    = '0;
                next_oh[j] = 1'b1;
            end
        end
        if (wrap) begin
            next_oh = FETCH_OH;
        end
    end

`ifdef STAGE_WATCHDOG_EN
    logic [7:0] wd_cnt;

    // A completing stage on the expiry edge wins over the watchdog
    assign force_fetch = (wd_cnt == WATCHDOG_CYCLES) & ~advance;

    always_ff @(posedge clk) begin
        if (clear) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (advance || force_fetch) begin
            wd_cnt  <= '0;
            timeout <= timeout | force_fetch;
        end else if (!halt) begin
            wd_cnt  <= wd_cnt + 8'd1;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
        if (clear) begin
            stage_n       <= ~FETCH_OH;
            stage_start   <= 1'b0;
            retire        <= 1'b0;
            retired_count <= '0;
            entered       <= 1'b0;
        end else begin
            entered     <= 1'b1;
            stage_start <= ~entered | advance | force_fetch;
            retire      <= advance & wrap;
            if (advance) begin
                stage_n <= ~next_oh;
                if (wrap) begin
                    retired_count <= retired_count + 16'd1;
                end
            end else if (force_fetch) begin
                stage_n <= ~FETCH_OH;
            end
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer (NUM_STAGES=5, WATCHDOG_CYCLES=4).
module tb_stage_sequencer;

    logic        clk;
    logic        clear;
    logic        stage_done;
    logic [4:0]  skip;
    logic        halt;
    logic [4:0]  stage_n;
    logic        stage_start;
    logic        retire;
    logic [15:0] retired_count;
`ifdef STAGE_WATCHDOG_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;

    stage_sequencer #(
        .NUM_STAGES      (5),
        .WATCHDOG_CYCLES (8'd4)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .stage_done    (stage_done),
        .skip          (skip),
        .halt          (halt),
        .stage_n       (stage_n),
        .stage_start   (stage_start),
        .retire        (retire),
        .retired_count (retired_count)
`ifdef STAGE_WATCHDOG_EN
        ,
        .timeout       (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        stage_done = 1'b0;
        halt       = 1'b0;
        skip       = 5'b00000;
        clear      = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear = 1'b1; stage_done = 1'b1; halt = 1'b0; skip = 5'b00000;
        tick();
        tick();
        checks++;
        if ({stage_n, stage_start, retire, retired_count} !== {5'b11110, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset: got n=%b s=%b r=%b cnt=%h want n=11110 s=0 r=0 cnt=0000",
                     stage_n, stage_start, retire, retired_count);
        end
        clear = 1'b0; stage_done = 1'b0;
        tick();
        checks++;
        if ({stage_n, stage_start, retire} !== {5'b11110, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL release_start: got n=%b s=%b r=%b want n=11110 s=1 r=0",
                     stage_n, stage_start, retire);
        end
        tick();
        checks++;
        if ({stage_n, stage_start} !== {5'b11110, 1'b0}) begin
            errors++;
            $display("FAIL release_hold: got n=%b s=%b want n=11110 s=0", stage_n, stage_start);
        end
    endtask

    task automatic test_sequence();
        logic [4:0] exp_n [5] = '{5'b11101, 5'b11011, 5'b10111, 5'b01111, 5'b11110};
        for (int k = 0; k < 5; k++) begin
            stage_done = 1'b1;
            tick();
            stage_done = 1'b0;
            checks++;
            if ({stage_n, stage_start, retire} !== {exp_n[k], 1'b1, (k == 4)}) begin
                errors++;
                $display("FAIL seq_enter %0d: got n=%b s=%b r=%b want n=%b s=1 r=%b",
                         k, stage_n, stage_start, retire, exp_n[k], (k == 4));
            end
            tick();
            checks++;
            if ({stage_n, stage_start, retire} !== {exp_n[k], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL seq_hold %0d: got n=%b s=%b r=%b want n=%b s=0 r=0",
                         k, stage_n, stage_start, retire, exp_n[k]);
            end
            tick();
        end
        checks++;
        if (retired_count !== 16'd1) begin
            errors++;
            $display("FAIL seq_count: got %h want 0001", retired_count);
        end
    endtask

    task automatic test_skip_hold();
        logic [4:0] exp_n [8] = '{5'b11101, 5'b11011, 5'b01111, 5'b11110,
                                  5'b11101, 5'b11011, 5'b01111, 5'b11110};
        do_clear();
        skip = 5'b01000;
        stage_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({stage_n, stage_start, retire} !== {exp_n[k], 1'b1, (k % 4 == 3)}) begin
                errors++;
                $display("FAIL skip_hold %0d: got n=%b s=%b r=%b want n=%b s=1 r=%b",
                         k, stage_n, stage_start, retire, exp_n[k], (k % 4 == 3));
            end
        end
        stage_done = 1'b0;
        checks++;
        if (retired_count !== 16'd2) begin
            errors++;
            $display("FAIL skip_hold_count: got %h want 0002", retired_count);
        end
    endtask

    task automatic test_all_skip();
        do_clear();
        skip = 5'b11110;
        stage_done = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({stage_n, stage_start, retire, retired_count} !== {5'b11110, 1'b1, 1'b1, 16'(k)}) begin
                errors++;
                $display("FAIL all_skip %0d: got n=%b s=%b r=%b cnt=%h want n=11110 s=1 r=1 cnt=%h",
                         k, stage_n, stage_start, retire, retired_count, 16'(k));
            end
        end
        stage_done = 1'b0;
        skip = 5'b00000;
    endtask

    task automatic test_halt();
        do_clear();
        stage_done = 1'b1;
        tick();
        tick();
        checks++;
        if (stage_n !== 5'b11011) begin
            errors++;
            $display("FAIL halt_setup: got n=%b want 11011", stage_n);
        end
        halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({stage_n, stage_start, retire} !== {5'b11011, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL halt %0d: got n=%b s=%b r=%b want n=11011 s=0 r=0",
                         k, stage_n, stage_start, retire);
            end
        end
        halt = 1'b0;
        stage_done = 1'b0;
        tick();
        tick();
        checks++;
        if ({stage_n, stage_start} !== {5'b11011, 1'b0}) begin
            errors++;
            $display("FAIL halt_release: got n=%b s=%b want n=11011 s=0", stage_n, stage_start);
        end
    endtask

    task automatic test_count_wrap();
        do_clear();
        skip = 5'b11110;
        stage_done = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            tick();
        end
        checks++;
        if (retired_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_preload: got %h want ffff", retired_count);
        end
        tick();
        checks++;
        if ({retired_count, retire} !== {16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL count_wrap: got cnt=%h r=%b want cnt=0000 r=1", retired_count, retire);
        end
        stage_done = 1'b0;
        skip = 5'b00000;
    endtask

    task automatic test_clear_mid();
        do_clear();
        stage_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        checks++;
        if ({stage_n, retired_count} !== {5'b10111, 16'd1}) begin
            errors++;
            $display("FAIL clear_setup: got n=%b cnt=%h want n=10111 cnt=0001", stage_n, retired_count);
        end
        clear = 1'b1;
        tick();
        checks++;
        if ({stage_n, stage_start, retire, retired_count} !== {5'b11110, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL clear_mid: got n=%b s=%b r=%b cnt=%h want n=11110 s=0 r=0 cnt=0000",
                     stage_n, stage_start, retire, retired_count);
        end
        clear = 1'b0;
        stage_done = 1'b0;
        tick();
    endtask

`ifdef STAGE_WATCHDOG_EN
    task automatic test_watchdog();
        do_clear();
        stage_done = 1'b1;
        tick();
        tick();
        tick();
        stage_done = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({stage_n, timeout} !== {5'b10111, 1'b0}) begin
                errors++;
                $display("FAIL wd_wait %0d: got n=%b t=%b want n=10111 t=0", k, stage_n, timeout);
            end
        end
        tick();
        checks++;
        if ({stage_n, timeout, retire, stage_start, retired_count} !==
            {5'b11110, 1'b1, 1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wd_expire: got n=%b t=%b r=%b s=%b cnt=%h want n=11110 t=1 r=0 s=1 cnt=0000",
                     stage_n, timeout, retire, stage_start, retired_count);
        end
        stage_done = 1'b1;
        tick();
        tick();
        stage_done = 1'b0;
        checks++;
        if ({stage_n, timeout} !== {5'b11011, 1'b1}) begin
            errors++;
            $display("FAIL wd_sticky: got n=%b t=%b want n=11011 t=1", stage_n, timeout);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({stage_n, timeout, stage_start, retire} !== {5'b11110, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wd_clear: got n=%b t=%b s=%b r=%b want n=11110 t=0 s=0 r=0",
                     stage_n, timeout, stage_start, retire);
        end
    endtask
`endif

    initial begin
        clear = 1'b1; stage_done = 1'b0; skip = 5'b00000; halt = 1'b0;
        test_reset();
        test_sequence();
        test_skip_hold();
        test_all_skip();
        test_halt();
        test_clear_mid();
`ifdef STAGE_WATCHDOG_EN
        test_watchdog();
`endif
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
